// File: rtl/synth_audio_pkg.sv
// Shared audio-path constants and helpers.
// Used by the I2S transmitter and its bit timer.
package synth_audio_pkg;

    // An I2S frame is two 32-bit slots, i.e. 64 BCLK periods.
    localparam int FRAME_BCLKS = 64;
    localparam int SLOT_BITS   = 32;
    localparam int SLOT_W      = $clog2(SLOT_BITS);

    // Frame counter bits when DIV = 1 (two Clocks per BCLK period).
    localparam int FRAME_W     = $clog2(2 * FRAME_BCLKS);

    // Offset-binary to two's complement: flip the sign bit of a w-bit value.
    function automatic logic [63:0] u2s(
        input logic [63:0] v,
        input int          w
    );
        logic [63:0] r;
        logic [5:0]  i;
        r    = v;
        i    = 6'(w - 1);
        r[i] = ~r[i];
        return r;
    endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// I2S frame timing: BCLK/LRCLK from one free-running frame counter.
// Also flags BCLK falling edges, the frame end and the next slot bit.
module i2s_bit_timer
    import synth_audio_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              bclk,
    output logic              lrclk,
    output logic              fall,
    output logic              frame_end,
    output logic [SLOT_W-1:0] next_bit
);

    localparam int LD    = $clog2(DIV);
    localparam int CNT_W = LD + FRAME_W;

    logic [CNT_W-1:0] cnt;

    // Frame counter c; FRAME is a power of two so it wraps by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // BCLK is low for the first DIV Clocks of every period.
    assign bclk      = cnt[LD];

    // Left slot is the first half of the frame.
    assign lrclk     = cnt[CNT_W-1];

    // Last Clock of a BCLK period: the next edge is a falling BCLK edge.
    assign fall      = &cnt[LD:0];

    // Last Clock of the frame.
    assign frame_end = &cnt;

    // Slot bit index of the BCLK period that starts after this falling edge.
    assign next_bit  = cnt[LD+SLOT_W:LD+1] + SLOT_W'(1);

endmodule

// File: rtl/wave_i2s_tx.sv
// Mono I2S transmitter: frame-averages the synth waveform into one sample.
// The averaged sample is sent in both slots during the following frame.
module wave_i2s_tx #(
    parameter int DIV      = 4,
    parameter int SAMPLE_W = 24
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [SAMPLE_W-1:0] Waveform,
    input  logic                Enable,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                SDATA,
    output logic [SAMPLE_W-1:0] Sample,
    output logic                SampleStrobe
);

    import synth_audio_pkg::*;

    localparam int LOG_FRAME = $clog2(DIV) + FRAME_W;
    localparam int ACC_W     = SAMPLE_W + LOG_FRAME;

    // Last slot bit that carries sample data (MSB sits at slot bit 1).
    localparam logic [SLOT_W-1:0] LAST_BIT = SLOT_W'(SAMPLE_W);

    logic                fall;
    logic                frame_end;
    logic [SLOT_W-1:0]   next_bit;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [SAMPLE_W-1:0] mean;
    logic [SAMPLE_W-1:0] signed_mean;
    logic [SAMPLE_W-1:0] load_val;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] shreg;
    logic                sdata;
    logic                strobe;

    i2s_bit_timer #(
        .DIV(DIV)
    ) timer (
        .clk      (Clock),
        .rst_n    (Reset),
        .bclk     (BCLK),
        .lrclk    (LRCLK),
        .fall     (fall),
        .frame_end(frame_end),
        .next_bit (next_bit)
    );

    // Running sum including this Clock's waveform value.
    assign acc_sum     = acc + ACC_W'(Waveform);

    // Truncated frame mean, then recentred around zero.
    assign mean        = acc_sum[ACC_W-1:LOG_FRAME];
    assign signed_mean = SAMPLE_W'(u2s(64'(mean), SAMPLE_W));

    // Enable is only looked at on the frame boundary.
    assign load_val    = Enable ? signed_mean : '0;

    // Accumulate every Clock; restart from zero for each new frame.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            acc <= '0;
        end else if (frame_end) begin
            acc <= '0;
        end else begin
            acc <= acc_sum;
        end
    end

    // Capture the new sample at the frame boundary and flag it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sample <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= frame_end;
            if (frame_end) begin
                sample <= load_val;
            end
        end
    end

    // Serialize on BCLK falling edges: one idle bit, the sample MSB-first,
    // then zero padding; the right slot reloads the same sample.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shreg <= '0;
            sdata <= 1'b0;
        end else if (fall) begin
            if (next_bit == '0) begin
                sdata <= 1'b0;
                shreg <= frame_end ? load_val : sample;
            end else if (next_bit <= LAST_BIT) begin
                sdata <= shreg[SAMPLE_W-1];
                shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
            end else begin
                sdata <= 1'b0;
            end
        end
    end

    assign Sample       = sample;
    assign SampleStrobe = strobe;
    assign SDATA        = sdata;

endmodule

// File: tb/tb_wave_i2s_tx.sv
// Bench for wave_i2s_tx: frame vectors, scoreboard of expected samples,
// cycle-level timing and serial-data model, async reset sequence.
module tb_wave_i2s_tx;

    localparam int DIV   = 4;
    localparam int SW    = 24;
    localparam int FRAME = 128 * DIV;
    localparam int NV    = 9;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [SW-1:0] Waveform;
    logic          Enable;
    logic          BCLK;
    logic          LRCLK;
    logic          SDATA;
    logic [SW-1:0] Sample;
    logic          SampleStrobe;

    wave_i2s_tx #(
        .DIV     (DIV),
        .SAMPLE_W(SW)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Waveform    (Waveform),
        .Enable      (Enable),
        .BCLK        (BCLK),
        .LRCLK       (LRCLK),
        .SDATA       (SDATA),
        .Sample      (Sample),
        .SampleStrobe(SampleStrobe)
    );

    always #5 Clock = ~Clock;

    typedef enum int { P_CONST, P_ALT, P_RAND } pat_e;

    typedef struct {
        pat_e          pat;
        logic [SW-1:0] val;
        logic          en;
        int            drop_at;
        logic [SW-1:0] exp;
        logic          use_exp;
    } vec_t;

    vec_t          vecs[NV];
    logic [SW-1:0] sbq[$];
    logic [SW-1:0] cur;
    int            checks;
    int            errors;
    int            cyc;
    int            tim_err;
    int            sd_err;
    int            strobes;
    int            rises;
    logic          prev_bclk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Per-negedge comparison against the spec-level frame model.
    task automatic monitor();
        int   c;
        int   s;
        logic exp_sd;
        c = cyc % FRAME;
        if (BCLK !== 1'(((c / DIV) % 2))) tim_err++;
        if (LRCLK !== (c >= FRAME / 2)) tim_err++;
        if (SampleStrobe !== (c == 0 && cyc > 0)) tim_err++;
        if (BCLK === 1'b1 && prev_bclk === 1'b0) rises++;
        prev_bclk = BCLK;
        if (SampleStrobe === 1'b1) begin
            strobes++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty strobe with no expected sample, got %0h",
                         Sample);
            end else begin
                cur = sbq.pop_front();
                check("sample", 64'(Sample), 64'(cur));
            end
        end
        s = (c / (2 * DIV)) % 32;
        exp_sd = 1'b0;
        if (s >= 1 && s <= SW) exp_sd = cur[SW-s];
        if (SDATA !== exp_sd) sd_err++;
    endtask

    task automatic step();
        @(posedge Clock);
        cyc++;
        @(negedge Clock);
        monitor();
    endtask

    task automatic frame_report(input int id, input bit full);
        check($sformatf("timing_f%0d", id), 64'(tim_err), 64'd0);
        check($sformatf("sdata_f%0d", id), 64'(sd_err), 64'd0);
        if (full) begin
            check($sformatf("strobes_f%0d", id), 64'(strobes), 64'd1);
            check($sformatf("bclk_rises_f%0d", id), 64'(rises), 64'd64);
        end
        tim_err = 0;
        sd_err  = 0;
        strobes = 0;
        rises   = 0;
    endtask

    // Drive n Clocks of a frame; push the expected sample at the boundary.
    task automatic run_frame(input vec_t v, input int n);
        longint        sum;
        logic [SW-1:0] w;
        logic [SW-1:0] mean;
        logic [SW-1:0] e;
        sum = 0;
        for (int c = 0; c < n; c++) begin
            if (c == 0) Enable = v.en;
            if (c == v.drop_at) Enable = 1'b0;
            case (v.pat)
                P_CONST: w = v.val;
                P_ALT:   w = (c % 2 == 1) ? {SW{1'b1}} : '0;
                default: w = SW'($urandom);
            endcase
            Waveform = w;
            sum += longint'(w);
            if (c == FRAME - 1) begin
                mean = SW'(sum >> $clog2(FRAME));
                e = Enable ? {~mean[SW-1], mean[SW-2:0]} : '0;
                sbq.push_back(v.use_exp ? v.exp : e);
            end
            step();
        end
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Reset     = 1'b1;
        cyc       = 0;
        cur       = '0;
        prev_bclk = 1'b0;
        tim_err   = 0;
        sd_err    = 0;
        strobes   = 0;
        rises     = 0;
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        errors   = 0;
        Reset    = 1'b0;
        Waveform = '0;
        Enable   = 1'b1;
        cur      = '0;

        vecs[0] = '{P_CONST, 24'hFFFFFF, 1'b1, -1, 24'h7FFFFF, 1'b1};
        vecs[1] = '{P_CONST, 24'hFFFFFF, 1'b1, -1, 24'h7FFFFF, 1'b1};
        vecs[2] = '{P_CONST, 24'h800000, 1'b1, -1, 24'h000000, 1'b1};
        vecs[3] = '{P_ALT,   24'h000000, 1'b1, -1, 24'hFFFFFF, 1'b1};
        vecs[4] = '{P_RAND,  24'h000000, 1'b1, -1, 24'h000000, 1'b0};
        vecs[5] = '{P_CONST, 24'hFFFFFF, 1'b1, 200, 24'h000000, 1'b1};
        vecs[6] = '{P_CONST, 24'hFFFFFF, 1'b0, -1, 24'h000000, 1'b1};
        vecs[7] = '{P_CONST, 24'h123456, 1'b1, -1, 24'h923456, 1'b1};
        vecs[8] = '{P_CONST, 24'h000000, 1'b1, -1, 24'h800000, 1'b1};

        repeat (3) @(negedge Clock);
        check("reset_outs", 64'({BCLK, LRCLK, SDATA, SampleStrobe, Sample}),
              64'd0);

        release_reset();
        for (int i = 0; i < NV; i++) begin
            run_frame(vecs[i], FRAME);
            frame_report(i, 1'b1);
        end

        // Asynchronous reset in the middle of a right slot.
        v = '{P_CONST, 24'h555555, 1'b1, -1, 24'hD55555, 1'b1};
        run_frame(v, 300);
        check("pre_reset_bclk", 64'(BCLK), 64'd1);
        frame_report(90, 1'b0);
        #2 Reset = 1'b0;
        #1 check("async_reset_outs",
                 64'({BCLK, LRCLK, SDATA, SampleStrobe, Sample}), 64'd0);
        sbq.delete();
        repeat (3) @(negedge Clock);
        check("held_reset_outs",
              64'({BCLK, LRCLK, SDATA, SampleStrobe, Sample}), 64'd0);

        release_reset();
        v = '{P_CONST, 24'hFFFFFF, 1'b1, -1, 24'h7FFFFF, 1'b1};
        run_frame(v, FRAME);
        frame_report(91, 1'b1);
        v = '{P_CONST, 24'h800000, 1'b1, -1, 24'h000000, 1'b1};
        run_frame(v, FRAME);
        frame_report(92, 1'b1);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
